if_id_assembler: RTL and testbench

- Receiving end of the instruction stream produced by the fetch stage.
- Samples each 16-bit fetched word with its PC and recognises two-word instructions, where an immediate word follows the opcode word.
- Presents one complete instruction (opcode word, immediate, PC) per valid beat to the decode stage.
- Passes decode back-pressure to fetch as a stall and discards partially assembled instructions on a taken-branch flush.

---
 rtl/if_id_assembler_pkg.sv | 20 ++
 rtl/if_id_assembler_if.sv | 27 ++
 rtl/if_id_assembler_inst_classifier.sv | 11 +
 rtl/if_id_assembler.sv | 121 ++++++++++++
 tb/tb_if_id_assembler.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/if_id_assembler_pkg.sv
// Shared pipeline definitions (package pipe_pkg): word/PC widths, immediate class, IF/ID FSM states.
package pipe_pkg;

  localparam int unsigned INST_W = 16;
  localparam int unsigned PC_W   = 32;

  localparam logic [2:0] IMM_CLASS = 3'b110;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_IMM = 2'd1,
    HOLD     = 2'd2
  } state_e;

  // Opcode words whose top three bits match IMM_CLASS are followed by an immediate word.
  function automatic logic is_two_word(input logic [INST_W-1:0] word);
    return word[INST_W-1 -: 3] == IMM_CLASS;
  endfunction

endpackage

// File: rtl/if_id_assembler_if.sv
// Fetch-to-decode handshake bundle; slave is the assembler, master is the fetch/decode side.
interface if_id_assembler_if;
  import pipe_pkg::*;

  logic [INST_W-1:0] fetch_inst;
  logic [PC_W-1:0]   fetch_pc;
  logic              fetch_valid;
  logic              flush;
  logic              id_stall;
  logic              fetch_stall;
  logic              id_valid;
  logic [INST_W-1:0] id_inst;
  logic [INST_W-1:0] id_imm;
  logic [PC_W-1:0]   id_pc;
  logic              id_two_word;

  modport master (
    output fetch_inst, fetch_pc, fetch_valid, flush, id_stall,
    input  fetch_stall, id_valid, id_inst, id_imm, id_pc, id_two_word
  );

  modport slave (
    input  fetch_inst, fetch_pc, fetch_valid, flush, id_stall,
    output fetch_stall, id_valid, id_inst, id_imm, id_pc, id_two_word
  );

endinterface

// File: rtl/if_id_assembler_inst_classifier.sv
// Combinational opcode classifier: flags opcode words that carry a trailing immediate word.
module inst_classifier
  import pipe_pkg::*;
(
  input  logic [INST_W-1:0] inst_i,
  output logic              two_word_o
);

  assign two_word_o = is_two_word(inst_i);

endmodule

// File: rtl/if_id_assembler.sv
// IF/ID assembler: builds one- and two-word instructions from the fetch stream for decode.
// Define IFID_PERF_EN to add the perf_insts / perf_flushed counters.
module if_id_assembler
  import pipe_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  if_id_assembler_if.slave     bus
`ifdef IFID_PERF_EN
  ,
  output logic [PC_W-1:0]      perf_insts,
  output logic [PC_W-1:0]      perf_flushed
`endif
);

  state_e            state_q, state_d;
  logic              id_valid_q, id_valid_d;
  logic [INST_W-1:0] id_inst_q, id_inst_d;
  logic [INST_W-1:0] id_imm_q, id_imm_d;
  logic [PC_W-1:0]   id_pc_q, id_pc_d;
  logic              id_two_word_q, id_two_word_d;
  logic              opcode_two_word;

  inst_classifier u_classifier (
    .inst_i     (bus.fetch_inst),
    .two_word_o (opcode_two_word)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      id_valid_q    <= 1'b0;
      id_inst_q     <= '0;
      id_imm_q      <= '0;
      id_pc_q       <= '0;
      id_two_word_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      id_valid_q    <= id_valid_d;
      id_inst_q     <= id_inst_d;
      id_imm_q      <= id_imm_d;
      id_pc_q       <= id_pc_d;
      id_two_word_q <= id_two_word_d;
    end
  end

  // A word is accepted only when no delivered instruction is being held by decode.
  always_comb begin
    state_d       = state_q;
    id_valid_d    = id_valid_q;
    id_inst_d     = id_inst_q;
    id_imm_d      = id_imm_q;
    id_pc_d       = id_pc_q;
    id_two_word_d = id_two_word_q;

    if (bus.flush) begin
      state_d       = IDLE;
      id_valid_d    = 1'b0;
      id_two_word_d = 1'b0;
    end else begin
      case (state_q)
        IDLE, HOLD: begin
          if (id_valid_q && bus.id_stall) begin
            state_d = HOLD;
          end else begin
            state_d    = IDLE;
            id_valid_d = 1'b0;
            if (bus.fetch_valid) begin
              id_inst_d     = bus.fetch_inst;
              id_pc_d       = bus.fetch_pc;
              id_two_word_d = 1'b0;
              if (opcode_two_word) begin
                state_d = WAIT_IMM;
              end else begin
                id_imm_d   = '0;
                id_valid_d = 1'b1;
              end
            end
          end
        end
        WAIT_IMM: begin
          if (bus.fetch_valid) begin
            id_imm_d      = bus.fetch_inst;
            id_two_word_d = 1'b1;
            id_valid_d    = 1'b1;
            state_d       = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.fetch_stall = bus.id_stall & id_valid_q;
  assign bus.id_valid    = id_valid_q;
  assign bus.id_inst     = id_inst_q;
  assign bus.id_imm      = id_imm_q;
  assign bus.id_pc       = id_pc_q;
  assign bus.id_two_word = id_two_word_q;

`ifdef IFID_PERF_EN
  logic [PC_W-1:0] perf_insts_q;
  logic [PC_W-1:0] perf_flushed_q;

  // Delivered = taken by decode without a flush; flushed = flush with something in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_insts_q   <= '0;
      perf_flushed_q <= '0;
    end else begin
      if (!bus.flush && id_valid_q && !bus.id_stall) perf_insts_q <= perf_insts_q + PC_W'(1);
      if (bus.flush && (id_valid_q || state_q == WAIT_IMM))
        perf_flushed_q <= perf_flushed_q + PC_W'(1);
    end
  end

  assign perf_insts   = perf_insts_q;
  assign perf_flushed = perf_flushed_q;
`endif

endmodule

// File: tb/tb_if_id_assembler.sv
// Scoreboard bench for if_id_assembler: directed scenarios plus a randomized fetch/decode stream.
module tb_if_id_assembler;

  typedef struct packed {
    logic [15:0] inst;
    logic [15:0] imm;
    logic [31:0] pc;
    logic        two;
  } exp_t;

  localparam int N_INST = 200;

  logic clk;
  logic reset;
  int   n_chk  = 0;
  int   n_pass = 0;
  exp_t exp_q[$];
  logic [15:0] prog_w[$];
  logic [31:0] prog_pc[$];

  if_id_assembler_if bus();

`ifdef IFID_PERF_EN
  logic [31:0] perf_insts;
  logic [31:0] perf_flushed;
`endif

  if_id_assembler dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef IFID_PERF_EN
    ,
    .perf_insts   (perf_insts),
    .perf_flushed (perf_flushed)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", name, act, req);
  endtask

  task automatic drive(input logic fv, input logic [15:0] w, input logic [31:0] pc,
                       input logic fl, input logic st);
    @(negedge clk);
    bus.fetch_valid = fv;
    bus.fetch_inst  = w;
    bus.fetch_pc    = pc;
    bus.flush       = fl;
    bus.id_stall    = st;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t mk(input logic [15:0] i, input logic [15:0] m,
                              input logic [31:0] p, input logic t);
    exp_t e;
    e.inst = i; e.imm = m; e.pc = p; e.two = t;
    return e;
  endfunction

  // Monitor: decode takes an instruction at the coming edge when valid, not stalled, not flushed.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!reset) begin
        chk("fetch_stall_rule", 128'(bus.fetch_stall), 128'(bus.id_stall & bus.id_valid));
        if (bus.id_valid && !bus.id_stall && !bus.flush) begin
          if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_delivery: actual inst %0h pc %0h required none",
                     bus.id_inst, bus.id_pc);
          end else begin
            e = exp_q.pop_front();
            chk("delivery", {bus.id_inst, bus.id_imm, bus.id_pc, bus.id_two_word},
                {e.inst, e.imm, e.pc, e.two});
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1);
  end

  initial begin
    int          idx;
    bit          acc;
    int          cyc;
    logic [15:0] w;
    logic [15:0] m;
    logic [31:0] pc;
    bit          two;

    reset = 1'b1;
    bus.fetch_valid = 1'b0; bus.fetch_inst = '0; bus.fetch_pc = '0;
    bus.flush = 1'b0; bus.id_stall = 1'b0;
    #12;
    chk("reset_values", {bus.id_valid, bus.id_inst, bus.id_imm, bus.id_pc, bus.id_two_word,
                         bus.fetch_stall}, 128'd0);
    #1 reset = 1'b0;

    // One-word delivery
    exp_q.push_back(mk(16'h1234, 16'h0, 32'd32, 1'b0));
    drive(1'b1, 16'h1234, 32'd32, 1'b0, 1'b0);
    after_edge();
    chk("one_word_valid", {bus.id_valid, bus.id_inst, bus.id_imm, bus.id_pc, bus.id_two_word},
        {1'b1, 16'h1234, 16'h0, 32'd32, 1'b0});

    // fetch_valid low in IDLE leaves the latched fields untouched
    drive(1'b0, 16'hFFFF, 32'd99, 1'b0, 1'b0);
    after_edge();
    chk("consumed_drop", 128'(bus.id_valid), 128'd0);
    drive(1'b0, 16'hFFFF, 32'd99, 1'b0, 1'b0);
    after_edge();
    chk("idle_no_change", {bus.id_valid, bus.id_inst, bus.id_pc}, {1'b0, 16'h1234, 32'd32});

    // Two-word delivery
    exp_q.push_back(mk(16'hC005, 16'h00FF, 32'd40, 1'b1));
    drive(1'b1, 16'hC005, 32'd40, 1'b0, 1'b0);
    after_edge();
    chk("two_word_wait", 128'(bus.id_valid), 128'd0);
    drive(1'b1, 16'h00FF, 32'd41, 1'b0, 1'b0);
    after_edge();
    chk("two_word_valid", {bus.id_valid, bus.id_inst, bus.id_imm, bus.id_pc, bus.id_two_word},
        {1'b1, 16'hC005, 16'h00FF, 32'd40, 1'b1});

    // Stall hold for three cycles with the next word presented and ignored
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 16'h1111, 32'd42, 1'b0, 1'b1);
      #1;
      chk("stall_fetch_stall", 128'(bus.fetch_stall), 128'd1);
      after_edge();
      chk("stall_frozen", {bus.id_valid, bus.id_inst, bus.id_imm, bus.id_pc, bus.id_two_word},
          {1'b1, 16'hC005, 16'h00FF, 32'd40, 1'b1});
    end
    exp_q.push_back(mk(16'h1111, 16'h0, 32'd42, 1'b0));
    drive(1'b1, 16'h1111, 32'd42, 1'b0, 1'b0);
    #1;
    chk("release_fetch_stall", 128'(bus.fetch_stall), 128'd0);
    after_edge();
    chk("release_accept", {bus.id_valid, bus.id_inst, bus.id_pc}, {1'b1, 16'h1111, 32'd42});

    // Flush in WAIT_IMM
    drive(1'b1, 16'hC005, 32'd50, 1'b0, 1'b0);
    after_edge();
    chk("flush_pre_wait", 128'(bus.id_valid), 128'd0);
    drive(1'b1, 16'hABCD, 32'd51, 1'b1, 1'b0);
    after_edge();
    chk("flush_wait_out", {bus.id_valid, bus.id_two_word}, 128'd0);
    exp_q.push_back(mk(16'h2000, 16'h0, 32'd52, 1'b0));
    drive(1'b1, 16'h2000, 32'd52, 1'b0, 1'b0);
    after_edge();
    chk("after_flush_one_word", {bus.id_valid, bus.id_inst, bus.id_imm, bus.id_pc, bus.id_two_word},
        {1'b1, 16'h2000, 16'h0, 32'd52, 1'b0});

    // Flush beats stall in HOLD; 16'h3000 must never reach decode
    drive(1'b1, 16'h3000, 32'd53, 1'b0, 1'b0);
    after_edge();
    drive(1'b0, 16'h0, 32'd0, 1'b0, 1'b1);
    #1;
    chk("hold_fetch_stall", 128'(bus.fetch_stall), 128'd1);
    after_edge();
    drive(1'b0, 16'h0, 32'd0, 1'b1, 1'b1);
    after_edge();
    chk("flush_beats_stall", {bus.id_valid, bus.fetch_stall, bus.id_two_word}, 128'd0);

    // Async reset while waiting for an immediate
    drive(1'b1, 16'hC005, 32'd60, 1'b0, 1'b0);
    after_edge();
    chk("wait_imm_pc", {bus.id_valid, bus.id_pc}, {1'b0, 32'd60});
    #1 reset = 1'b1;
    #1;
    chk("async_reset", {bus.id_valid, bus.id_inst, bus.id_imm, bus.id_pc, bus.id_two_word,
                        bus.fetch_stall}, 128'd0);
`ifdef IFID_PERF_EN
    chk("perf_reset", {perf_insts, perf_flushed}, 128'd0);
`endif
    #1 reset = 1'b0;
    exp_q.push_back(mk(16'h4444, 16'h0, 32'd61, 1'b0));
    drive(1'b1, 16'h4444, 32'd61, 1'b0, 1'b0);
    after_edge();
    chk("post_reset_idle", {bus.id_valid, bus.id_inst, bus.id_imm, bus.id_two_word},
        {1'b1, 16'h4444, 16'h0, 1'b0});

    // Random program: expected instructions are the program itself, in order
    pc = $urandom;
    for (int i = 0; i < N_INST; i++) begin
      two = 1'($urandom_range(1));
      w   = 16'($urandom);
      if (two) w[15:13] = 3'b110;
      else if (w[15:13] == 3'b110) w[15:13] = 3'($urandom_range(5));
      m = 16'($urandom);
      prog_w.push_back(w);
      prog_pc.push_back(pc);
      if (two) begin
        prog_w.push_back(m);
        prog_pc.push_back(pc + 32'd1);
      end
      exp_q.push_back(mk(w, two ? m : 16'h0, pc, two));
      pc = pc + (two ? 32'd2 : 32'd1);
    end

    idx = 0;
    acc = 1'b0;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 20000) begin
      @(negedge clk);
      if (acc) idx++;
      bus.flush       = 1'b0;
      bus.id_stall    = ($urandom_range(9) < 3);
      bus.fetch_valid = (idx < prog_w.size()) && ($urandom_range(3) != 0);
      if (idx < prog_w.size()) begin
        bus.fetch_inst = prog_w[idx];
        bus.fetch_pc   = prog_pc[idx];
      end
      #1 acc = bus.fetch_valid && !bus.fetch_stall;
      cyc++;
    end
    n_chk++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL random_drain: actual %0d pending required 0", exp_q.size());

    drive(1'b0, 16'h0, 32'd0, 1'b0, 1'b0);
    drive(1'b0, 16'h0, 32'd0, 1'b0, 1'b0);
    after_edge();
    chk("random_all_words_used", 128'(idx), 128'(prog_w.size()));
    chk("final_idle", {bus.id_valid, bus.fetch_stall}, 128'd0);
`ifdef IFID_PERF_EN
    chk("perf_counts", {perf_insts, perf_flushed}, {32'(N_INST + 1), 32'd0});
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
